alu_pipe: RTL
=============

# alu_pipe

Parametrised, registered successor to the team's 5-bit combinational ALU. It keeps that ALU's opcode map and adds ADD, SUB and an iterative multi-cycle MUL. Results come back with status flags over a valid/ready handshake. It sits between the operand/opcode issue logic and the result writeback, and replaces the combinational unit wherever a clocked, back-pressurable datapath is needed.

## Interface
- WIDTH, 5: operand/result width; must be ≥ 2.
- SHAMT, 2: fixed right-shift amount for op 0111; must be < WIDTH.
- DEFAULT_VAL, 6: result driven for undefined opcodes, truncated to WIDTH.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; a transfer occurs on an edge where in_valid && in_ready.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- op  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  downstream accepts; a transfer occurs on an edge where out_valid && out_ready.
- result  out  WIDTH  registered result.
- flags  out  4  {err, ovf, carry, zero}, registered with result.
- busy  out  1  high while in state MUL.

## Operation
- Operands and opcode are captured on accept; later input changes do not affect an in-flight operation.
- Opcodes, with WIDTH-bit results:
  - 1101: ~(A&B).
  - 1100: A ~^ B.
  - 0111: A >> SHAMT, logical.
  - 0101: rotate B left by 1, {B[W-2:0], B[W-1]}.
  - 0001: max(A,B), unsigned.
  - 0000: all-ones if A>B, else 0.
  - 0010: A+B. carry = carry-out.
  - 0011: A−B. carry = borrow, i.e. A<B.
  - 1000: A*B. result = low WIDTH bits; ovf = (high WIDTH bits ≠ 0).
  - Any other opcode: result = DEFAULT_VAL, err = 1.
- zero = (result == 0) for every opcode, including undefined ones.
- Flags not defined for an opcode are 0.
- The multiplier is iterative shift-add, one multiplier bit per cycle, using a 2·WIDTH-bit accumulator and a bit counter.
- State machine: IDLE, MUL, DONE.
  - IDLE, accept with op≠1000: compute, load result/flags → DONE.
  - IDLE, accept with op=1000: clear accumulator, counter=0 → MUL.
  - MUL: one iteration per cycle. After iteration WIDTH−1, load result/flags → DONE. No abort path.
  - DONE, out_ready=0: hold result/flags/out_valid stable.
  - DONE, out_ready=1, no accept → IDLE.
  - DONE, out_ready=1, simultaneous accept: behave as an IDLE accept on the same edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only and never depends on in_valid.
- out_valid = (state==DONE).
- busy = (state==MUL).

## Timing
- Reset, asserted asynchronously and mid-operation included: state=IDLE, result=0, flags=0, out_valid=0, busy=0, counter and accumulator=0. in_ready=1 while reset is held and after release.
- Single-cycle ops: accept on edge k; out_valid=1 after edge k with final result.
- MUL: accept on edge k; busy=1 after edges k … k+WIDTH−1; out_valid=1 after edge k+WIDTH. Latency is WIDTH+1 edges; in_ready=0 throughout MUL.
- Throughput: with out_ready held high, one single-cycle op per clock, back-to-back.
- An output stalled by out_ready=0 holds indefinitely, with no loss and no overwrite.
- in_valid without in_ready: nothing is captured; the source must hold its data.

## Test plan
- Reset mid-MUL: assert rst during busy -> out_valid=0, result=0, flags=0, in_ready=1 immediately; next op after release executes normally.
- WIDTH=5, A=22, B=13, ops 1101/0001/0000/0101 issued back-to-back with out_ready=1 -> results 27, 22, 31, 26 on consecutive cycles; flags 0000 each.
- ADD 20+15 -> result 3, carry=1. SUB 3−5 -> result 30, carry=1. SUB 7−7 -> result 0, zero=1, carry=0.
- MUL 6*7 -> out_valid exactly 6 edges after accept; result 10, ovf=1. MUL 3*5 -> result 15, ovf=0.
- Undefined op 1111 -> result 6, err=1. Op 0111 with A=31 -> result 7.
- Backpressure: hold out_ready=0 for 4 cycles after a result with in_valid=1 -> result stable, in_ready=0. Raise out_ready -> old result consumed and new op accepted on the same edge.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue/result handshake bundle for alu_pipe
interface alu_pipe_if #(parameter int WIDTH = 5);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;
    modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, result, flags, busy);
    modport slave  (input in_valid, a, b, op, out_ready, output in_ready, out_valid, result, flags, busy);
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake and iterative shift-add multiplier
module alu_pipe #(
    parameter int WIDTH       = 5,
    parameter int SHAMT       = 2,
    parameter int DEFAULT_VAL = 6
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1000;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t             state, state_n;
    logic [WIDTH-1:0]   ma, mb, res_n, result_q;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [CW-1:0]      cnt;
    logic [3:0]         flg_n, flags_q;
    logic [WIDTH:0]     sum, dif;
    logic               accept, last, err, car;
    assign bus.in_ready  = state == IDLE || (state == DONE && bus.out_ready);
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state == MUL;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign accept = bus.in_valid && bus.in_ready;
    assign last   = cnt == CW'(WIDTH - 1);
    assign acc_n  = acc + (mb[cnt] ? {{WIDTH{1'b0}}, ma} << cnt : '0);
    assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
    assign dif    = {1'b0, bus.a} - {1'b0, bus.b};
    always_comb begin
        err   = 1'b0;
        car   = 1'b0;
        res_n = WIDTH'(DEFAULT_VAL);
        case (bus.op)
            4'b1101: res_n = ~(bus.a & bus.b);
            4'b1100: res_n = bus.a ~^ bus.b;
            4'b0111: res_n = bus.a >> SHAMT;
            4'b0101: res_n = {bus.b[WIDTH-2:0], bus.b[WIDTH-1]};
            4'b0001: res_n = bus.a > bus.b ? bus.a : bus.b;
            4'b0000: res_n = bus.a > bus.b ? '1 : '0;
            4'b0010: {car, res_n} = sum;
            4'b0011: {car, res_n} = dif;
            OP_MUL:  res_n = '0;
            default: err = 1'b1;
        endcase
        flg_n = {err, 1'b0, car, res_n == '0};
    end
    always_comb
        state_n = accept ? (bus.op == OP_MUL ? MUL : DONE) :
                  state == MUL ? (last ? DONE : MUL) :
                  (state == DONE && bus.out_ready) ? IDLE : state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ma       <= '0;
            mb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                ma  <= bus.a;
                mb  <= bus.b;
                acc <= '0;
                cnt <= '0;
                if (bus.op != OP_MUL) begin
                    result_q <= res_n;
                    flags_q  <= flg_n;
                end
            end else if (state == MUL) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result_q <= acc_n[WIDTH-1:0];
                    flags_q  <= {1'b0, |acc_n[2*WIDTH-1:WIDTH], 1'b0, ~|acc_n[WIDTH-1:0]};
                end
            end
        end
    end
endmodule
